// File: rtl/nor_reduce_pipe_pkg.sv
// rtl/nor_reduce_pipe_pkg.sv - shared op encodings and tree-geometry helpers for nor_reduce_pipe
package nor_reduce_pkg;

  localparam logic [1:0] OP_NOR  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_NAND = 2'b10;
  localparam logic [1:0] OP_AND  = 2'b11;

  // Width of the vector after j tree levels (j=0 is the raw input).
  function automatic int level_width(input int n, input int k, input int j);
    int w;
    w = n;
    for (int i = 0; i < j; i++) begin
      w = (w + k - 1) / k;
    end
    return w;
  endfunction

  // Number of tree levels; a 1-bit input still gets one registered level.
  function automatic int clog_k(input int n, input int k);
    int w;
    int l;
    w = n;
    l = 0;
    while (w > 1) begin
      w = (w + k - 1) / k;
      l++;
    end
    if (l < 1) l = 1;
    return l;
  endfunction

  // Bit offset of level j inside a bus that concatenates levels 0..j-1.
  function automatic int level_offset(input int n, input int k, input int j);
    int off;
    off = 0;
    for (int i = 0; i < j; i++) begin
      off += level_width(n, k, i);
    end
    return off;
  endfunction

  // AND-family ops reduce with AND and pad with 1; OR-family with OR and pad with 0.
  function automatic logic op_is_and(input logic [1:0] op);
    logic r;
    case (op)
      OP_NOR:  r = 1'b0;
      OP_OR:   r = 1'b0;
      OP_NAND: r = 1'b1;
      OP_AND:  r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Inverting ops flip the result, but only at the final level.
  function automatic logic op_inverts(input logic [1:0] op);
    logic r;
    case (op)
      OP_NOR:  r = 1'b1;
      OP_OR:   r = 1'b0;
      OP_NAND: r = 1'b1;
      OP_AND:  r = 1'b0;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/nor_reduce_pipe_level.sv
// rtl/nor_reduce_pipe_level.sv - one registered, elastic K-ary reduction level
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   upstream handshake; in_ready = !valid_q | move
//   in_data[IN_W]       vector from the previous level
//   in_op[2]            op travelling with in_data
//   out_valid/out_ready downstream handshake
//   out_data[ceil(IN_W/K)] group-reduced vector
//   out_op[2]           op travelling with out_data
module reduce_level
  import nor_reduce_pkg::*;
#(
  parameter int IN_W = 7,
  parameter int K    = 4,
  parameter bit LAST = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [IN_W-1:0]               in_data,
  input  logic [1:0]                    in_op,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [((IN_W+K-1)/K)-1:0]     out_data,
  output logic [1:0]                    out_op
);

  localparam int OUT_W = (IN_W + K - 1) / K;
  localparam int PAD_W = OUT_W * K;

  logic             valid_q, valid_d;
  logic [1:0]       op_q, op_d;
  logic [OUT_W-1:0] data_q, data_d;

  logic             and_mode;
  logic [PAD_W-1:0] padded;
  logic [OUT_W-1:0] reduced;
  logic             load;

  // Pad the ragged top group with the op's identity so it reduces like a full group.
  always_comb begin
    and_mode = op_is_and(in_op);
    padded   = {PAD_W{and_mode}};
    padded[IN_W-1:0] = in_data;
    reduced  = '0;
    for (int g = 0; g < OUT_W; g++) begin
      reduced[g] = and_mode ? (&padded[g*K +: K]) : (|padded[g*K +: K]);
      if (LAST && op_inverts(in_op)) begin
        reduced[g] = ~reduced[g];
      end
    end
  end

  // Empty, or emptying this cycle, means we can take a new item.
  assign in_ready = !valid_q || out_ready;
  // Data/op only capture on a real transfer, so idle X never enters the pipe.
  assign load     = in_valid && in_ready;

  always_comb begin
    valid_d = valid_q;
    op_d    = op_q;
    data_d  = data_q;
    if (in_ready) begin
      valid_d = in_valid;
    end
    if (load) begin
      op_d   = in_op;
      data_d = reduced;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      op_q    <= 2'b00;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      op_q    <= op_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_op    = op_q;
  assign out_data  = data_q;

endmodule

// File: rtl/nor_reduce_pipe.sv
// rtl/nor_reduce_pipe.sv - pipelined N-bit NOR/OR/NAND/AND reduction tree with valid/ready
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    input handshake
//   in_data[N]           vector to reduce
//   in_op[2]             00 NOR, 01 OR, 10 NAND, 11 AND
//   out_valid/out_ready  output handshake
//   out_data             reduction result
//   out_op[2]            op that produced out_data
module nor_reduce_pipe
  import nor_reduce_pkg::*;
#(
  parameter int N = 7,
  parameter int K = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic [1:0]   in_op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_data,
  output logic [1:0]   out_op
);

  localparam int L     = clog_k(N, K);
  localparam int BUS_W = level_offset(N, K, L + 1);

  // Every level's vector lives in one concatenated bus; level 0 is in_data.
  logic [BUS_W-1:0] lvl_data;
  logic [L:0]       lvl_valid;
  logic [L:0]       lvl_ready;
  logic [2*L+1:0]   lvl_op;

  assign lvl_data[N-1:0] = in_data;
  assign lvl_op[1:0]     = in_op;
  assign lvl_valid[0]    = in_valid;
  assign lvl_ready[L]    = out_ready;
  assign in_ready        = lvl_ready[0];

  // Ready ripples combinationally from out_ready back to in_ready so a full
  // pipe can accept and drain on the same edge.
  for (genvar j = 1; j <= L; j++) begin : g_level
    localparam int IW      = level_width(N, K, j - 1);
    localparam int OW      = level_width(N, K, j);
    localparam int OFF_IN  = level_offset(N, K, j - 1);
    localparam int OFF_OUT = level_offset(N, K, j);

    reduce_level #(
      .IN_W (IW),
      .K    (K),
      .LAST (j == L)
    ) u_level (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (lvl_valid[j-1]),
      .in_ready  (lvl_ready[j-1]),
      .in_data   (lvl_data[OFF_IN +: IW]),
      .in_op     (lvl_op[2*(j-1) +: 2]),
      .out_valid (lvl_valid[j]),
      .out_ready (lvl_ready[j]),
      .out_data  (lvl_data[OFF_OUT +: OW]),
      .out_op    (lvl_op[2*j +: 2])
    );
  end

  assign out_valid = lvl_valid[L];
  assign out_data  = lvl_data[level_offset(N, K, L)];
  assign out_op    = lvl_op[2*L +: 2];

endmodule

// File: tb/tb_nor_reduce_pipe.sv
// tb/tb_nor_reduce_pipe.sv - self-checking bench for nor_reduce_pipe (N7/K4, N16/K2, N1/K4)
module tb_nor_reduce_pipe;

  localparam int NW  [3] = '{7, 16, 1};
  localparam int LAT [3] = '{2, 4, 1};

  logic        clk;
  logic        rst;
  logic [2:0]  in_valid;
  logic [2:0]  in_ready;
  logic [15:0] din [3];
  logic [1:0]  iop [3];
  logic [2:0]  out_valid;
  logic [2:0]  out_ready;
  logic [2:0]  out_data;
  logic [1:0]  oop [3];

  nor_reduce_pipe #(.N(7), .K(4)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(din[0][6:0]), .in_op(iop[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_data(out_data[0]), .out_op(oop[0]));

  nor_reduce_pipe #(.N(16), .K(2)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(din[1]), .in_op(iop[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_data(out_data[1]), .out_op(oop[1]));

  nor_reduce_pipe #(.N(1), .K(4)) u_c (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(din[2][0:0]), .in_op(iop[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .out_data(out_data[2]), .out_op(oop[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int passes = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic ref_red(input logic [15:0] d, input int n, input logic [1:0] op);
    logic r;
    r = op[1];
    for (int i = 0; i < n; i++) begin
      r = op[1] ? (r & d[i]) : (r | d[i]);
    end
    return op[0] ? r : ~r;
  endfunction

  typedef struct {
    int         dut;
    logic       d;
    logic [1:0] op;
    int         cyc;
  } sb_t;

  sb_t        sbq [$];
  int         cyc = 0;
  int         outcnt  [3];
  int         lat_sum [3];
  int         last_lat[3];
  logic [2:0] last_data;
  logic [1:0] last_op [3];
  logic [2:0] stall_prev = 3'b000;
  logic [2:0] hold_d;
  logic [1:0] hold_op [3];

  // Scoreboard: push reference result on accept, pop and compare on output transfer.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      sbq.delete();
      stall_prev = 3'b000;
    end else begin
      for (int d = 0; d < 3; d++) begin
        if (stall_prev[d]) begin
          chk("hold_valid", out_valid[d], 1'b1);
          chk("hold_data", out_data[d], hold_d[d]);
          chk("hold_op", oop[d], hold_op[d]);
        end
        stall_prev[d] = out_valid[d] & ~out_ready[d];
        hold_d[d]     = out_data[d];
        hold_op[d]    = oop[d];
        if (out_valid[d] && out_ready[d]) begin
          int idx;
          idx = -1;
          for (int i = 0; i < sbq.size(); i++) begin
            if (sbq[i].dut == d) begin
              idx = i;
              break;
            end
          end
          chk("sb_found", (idx >= 0), 1'b1);
          if (idx >= 0) begin
            chk("sb_data", out_data[d], sbq[idx].d);
            chk("sb_op", oop[d], sbq[idx].op);
            last_lat[d] = cyc - sbq[idx].cyc;
            lat_sum[d] += last_lat[d];
            sbq.delete(idx);
          end
          last_data[d] = out_data[d];
          last_op[d]   = oop[d];
          outcnt[d]++;
        end
        if (in_valid[d] && in_ready[d]) begin
          sbq.push_back('{d, ref_red(din[d], NW[d], iop[d]), iop[d], cyc});
        end
      end
    end
  end

  logic [1:0]  vq_op  [$];
  logic [15:0] vq_dat [$];
  int          vi;

  task automatic wait_out(input int d, input int target, input string tag);
    int n;
    n = 0;
    while (outcnt[d] < target && n < 60) begin
      @(negedge clk); #1;
      n++;
    end
    chk(tag, outcnt[d], target);
    @(posedge clk); #1;
  endtask

  // Present queued vectors back-to-back on DUT d, advancing only on transfer.
  task automatic run(input int d, input int maxc, output int used);
    bit acc;
    int c;
    for (c = 0; c < maxc && vi < vq_dat.size(); c++) begin
      in_valid[d] = 1'b1;
      din[d]      = vq_dat[vi];
      iop[d]      = vq_op[vi];
      @(negedge clk);
      acc = in_valid[d] & in_ready[d];
      @(posedge clk); #1;
      if (acc) vi++;
      in_valid[d] = 1'b0;
      din[d]      = 'x;
    end
    used = c;
  endtask

  task automatic single(input int d, input logic [1:0] op, input logic [15:0] dat,
                        input logic exp, input string tag);
    int base;
    int n;
    bit acc;
    base = outcnt[d];
    in_valid[d] = 1'b1;
    din[d]      = dat;
    iop[d]      = op;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 20) begin
      @(negedge clk);
      acc = in_valid[d] & in_ready[d];
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_accept"}, acc, 1'b1);
    in_valid[d] = 1'b0;
    din[d]      = 'x;
    n = 0;
    while (outcnt[d] == base && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    chk({tag, "_count"}, outcnt[d] - base, 1);
    chk({tag, "_lat"}, last_lat[d], LAT[d]);
    chk({tag, "_data"}, last_data[d], exp);
    chk({tag, "_op"}, last_op[d], op);
    @(posedge clk); #1;
  endtask

  initial begin
    int         used;
    int         base;
    int         lsum;
    int         sent [3];
    int         base3[3];
    bit [2:0]   acc;
    logic [15:0] v;

    // 1. Reset with in_valid held high.
    rst       = 1'b1;
    in_valid  = 3'b111;
    out_ready = 3'b111;
    for (int d = 0; d < 3; d++) begin
      din[d] = 16'h0000;
      iop[d] = 2'b00;
    end
    @(posedge clk);
    @(negedge clk);
    chk("rst_ov_0", out_valid[0], 1'b0);
    chk("rst_od_0", out_data[0], 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_ov_1", out_valid[0], 1'b0);
    chk("rst_od_1", out_data[0], 1'b0);
    @(posedge clk); #1;
    rst      = 1'b0;
    in_valid = 3'b000;
    for (int d = 0; d < 3; d++) din[d] = 'x;
    @(negedge clk);
    chk("rst_in_ready", in_ready[0], 1'b1);
    chk("rst_out_valid", out_valid[0], 1'b0);
    chk("rst_out_op", oop[0], 2'b00);
    @(posedge clk); #1;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_no_result", outcnt[0], 0);

    // 2. Each op on the default 7-bit, 4-ary tree.
    single(0, 2'b00, 16'h0000, 1'b1, "nor_00");
    single(0, 2'b00, 16'h0004, 1'b0, "nor_04");
    single(0, 2'b01, 16'h0040, 1'b1, "or_40");
    single(0, 2'b10, 16'h007F, 1'b0, "nand_7f");
    single(0, 2'b11, 16'h007F, 1'b1, "and_7f");
    single(0, 2'b11, 16'h003F, 1'b0, "and_3f");

    // 3. Back-to-back stream at full throughput.
    vq_op.delete(); vq_dat.delete(); vi = 0;
    for (int i = 0; i < 8; i++) begin
      vq_op.push_back(2'b00);
      vq_dat.push_back((i % 2 == 0) ? 16'h0000 : 16'h0001);
    end
    base = outcnt[0];
    lsum = lat_sum[0];
    run(0, 20, used);
    chk("thru_cycles", used, 8);
    wait_out(0, base + 8, "thru_out");
    chk("thru_lat_sum", lat_sum[0] - lsum, 16);

    // 4. Backpressure: capacity L, then drain in order.
    vq_op.delete(); vq_dat.delete(); vi = 0;
    vq_op.push_back(2'b00); vq_dat.push_back(16'h0000);
    vq_op.push_back(2'b01); vq_dat.push_back(16'h0000);
    vq_op.push_back(2'b10); vq_dat.push_back(16'h007F);
    vq_op.push_back(2'b11); vq_dat.push_back(16'h007F);
    base = outcnt[0];
    out_ready[0] = 1'b0;
    run(0, 6, used);
    chk("bp_accepted", vi, 2);
    @(negedge clk);
    chk("bp_in_ready", in_ready[0], 1'b0);
    chk("bp_valid", out_valid[0], 1'b1);
    chk("bp_head", out_data[0], 1'b1);
    repeat (3) @(negedge clk);
    chk("bp_head_held", out_data[0], 1'b1);
    chk("bp_none_out", outcnt[0] - base, 0);
    @(posedge clk); #1;
    out_ready[0] = 1'b1;
    run(0, 20, used);
    chk("bp_all_accepted", vi, 4);
    wait_out(0, base + 4, "bp_out");

    // 5. Reset with two vectors in flight.
    vq_op.delete(); vq_dat.delete(); vi = 0;
    vq_op.push_back(2'b00); vq_dat.push_back(16'h0000);
    vq_op.push_back(2'b01); vq_dat.push_back(16'h0040);
    out_ready[0] = 1'b0;
    run(0, 4, used);
    chk("mid_accepted", vi, 2);
    base = outcnt[0];
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_out_valid", out_valid[0], 1'b0);
    chk("mid_in_ready", in_ready[0], 1'b1);
    @(posedge clk); #1;
    out_ready[0] = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("mid_none", outcnt[0] - base, 0);
    single(0, 2'b01, 16'h0002, 1'b1, "mid_post");

    // 6. Other geometries: latency, then random streams under random out_ready.
    single(1, 2'b11, 16'hFFFF, 1'b1, "b_and_ff");
    single(1, 2'b00, 16'h8000, 1'b0, "b_nor_msb");
    single(2, 2'b00, 16'h0000, 1'b1, "c_nor_0");
    single(2, 2'b10, 16'h0001, 1'b0, "c_nand_1");

    for (int d = 0; d < 3; d++) begin
      sent[d]  = 0;
      base3[d] = outcnt[d];
    end
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      acc = in_valid & in_ready;
      @(posedge clk); #1;
      for (int d = 0; d < 3; d++) begin
        if (!in_valid[d] || acc[d]) begin
          if (sent[d] < 1000 && $urandom_range(0, 3) != 0) begin
            v = 16'($urandom);
            case ($urandom_range(0, 3))
              0: v = 16'h0000;
              1: v = 16'hFFFF;
              2: v = 16'(1 << $urandom_range(0, 15)) ^ (($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'h0000);
              default: ;
            endcase
            in_valid[d] = 1'b1;
            din[d]      = v;
            iop[d]      = 2'($urandom);
            sent[d]++;
          end else begin
            in_valid[d] = 1'b0;
            din[d]      = 'x;
          end
        end
        out_ready[d] = 1'($urandom_range(0, 1));
      end
      if (sent[0] == 1000 && sent[1] == 1000 && sent[2] == 1000 && in_valid == 3'b000) break;
    end
    out_ready = 3'b111;
    for (int d = 0; d < 3; d++) begin
      chk("rand_sent", sent[d], 1000);
      wait_out(d, base3[d] + 1000, "rand_out");
    end
    chk("rand_sb_empty", sbq.size(), 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
